// File: rtl/lpc_frame_ctrl.sv
// Frame scheduler between LPC encoder and decoder: 2-entry coefficient frame buffer plus decoder launch FSM.
// Optional voiced pitch clamping to [PMIN, PMAX] is enabled by defining LPC_FRAME_CTRL_PITCH_CLAMP_EN.
module lpc_frame_ctrl #(
  parameter int unsigned FRAME_LEN = 160,
  parameter int unsigned PMIN      = 20
`ifdef LPC_FRAME_CTRL_PITCH_CLAMP_EN
  , parameter int unsigned PMAX    = 400
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         smp_v,
  input  logic [15:0]  smp_x,
  output logic         enc_v,
  output logic [15:0]  enc_x,
  input  logic         enc_vout,
  input  logic         enc_voiced,
  input  logic [175:0] enc_a,
  input  logic [15:0]  enc_freq_count,
  output logic         dec_v,
  output logic         dec_voiced,
  output logic [175:0] dec_a,
  output logic [15:0]  dec_pulserate,
  output logic [15:0]  dec_lpcrate,
  input  logic         dec_vout,
  input  logic [15:0]  dec_synth,
  output logic         out_v,
  output logic [15:0]  out_synth,
  output logic [15:0]  smp_cnt,
  output logic [15:0]  frames_played,
  output logic         overrun,
  output logic         underrun
);

  localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);
  localparam logic [15:0] PMIN_W      = 16'(PMIN);
`ifdef LPC_FRAME_CTRL_PITCH_CLAMP_EN
  localparam logic [15:0] PMAX_W      = 16'(PMAX);
`endif

  typedef enum logic [1:0] {IDLE, LAUNCH, PLAY} state_e;

  state_e         state_q, state_d;
  logic           enc_v_q, enc_v_d;
  logic [15:0]    enc_x_q, enc_x_d;
  logic           out_v_q, out_v_d;
  logic [15:0]    out_synth_q, out_synth_d;
  logic [15:0]    smp_cnt_q, smp_cnt_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     occ_q, occ_d;
  logic [1:0]     buf_voiced_q, buf_voiced_d;
  logic [175:0]   buf_a_q [2];
  logic [175:0]   buf_a_d [2];
  logic [15:0]    buf_pr_q [2];
  logic [15:0]    buf_pr_d [2];
  logic           dec_voiced_q, dec_voiced_d;
  logic [175:0]   dec_a_q, dec_a_d;
  logic [15:0]    dec_pr_q, dec_pr_d;
  logic [15:0]    play_cnt_q, play_cnt_d;
  logic [15:0]    frames_q, frames_d;
  logic           overrun_q, overrun_d;
  logic           underrun_q, underrun_d;

  logic           push, pop;
  logic [15:0]    new_pr;

  // The pop happens in LAUNCH; a push into a full buffer is only accepted alongside that pop.
  assign pop   = (state_q == LAUNCH);
  assign push  = enc_vout && ((occ_q != 2'd2) || pop);
  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    new_pr = PMIN_W;
    if (enc_voiced) begin
`ifdef LPC_FRAME_CTRL_PITCH_CLAMP_EN
      if (enc_freq_count < PMIN_W) begin
        new_pr = PMIN_W;
      end else if (enc_freq_count > PMAX_W) begin
        new_pr = PMAX_W;
      end else begin
        new_pr = enc_freq_count;
      end
`else
      new_pr = enc_freq_count;
`endif
    end
  end

  always_comb begin
    enc_v_d      = smp_v;
    enc_x_d      = smp_x;
    out_v_d      = dec_vout;
    out_synth_d  = dec_synth;
    smp_cnt_d    = smp_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    buf_voiced_d = buf_voiced_q;
    buf_a_d      = buf_a_q;
    buf_pr_d     = buf_pr_q;
    overrun_d    = overrun_q;

    if (smp_v) begin
      smp_cnt_d = (smp_cnt_q == FRAME_LEN_W - 16'd1) ? 16'd0 : smp_cnt_q + 16'd1;
    end

    if (push) begin
      buf_voiced_d[wr_ptr_q] = enc_voiced;
      buf_a_d[wr_ptr_q]      = enc_a;
      buf_pr_d[wr_ptr_q]     = new_pr;
      wr_ptr_d               = ~wr_ptr_q;
    end else if (enc_vout) begin
      overrun_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    dec_voiced_d = dec_voiced_q;
    dec_a_d      = dec_a_q;
    dec_pr_d     = dec_pr_q;
    play_cnt_d   = play_cnt_q;
    frames_d     = frames_q;
    underrun_d   = underrun_q;

    case (state_q)
      IDLE: begin
        if (occ_d != 2'd0) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        dec_voiced_d = buf_voiced_q[rd_ptr_q];
        dec_a_d      = buf_a_q[rd_ptr_q];
        dec_pr_d     = buf_pr_q[rd_ptr_q];
        play_cnt_d   = 16'd0;
        state_d      = PLAY;
      end
      PLAY: begin
        if (dec_vout) begin
          if (play_cnt_q == FRAME_LEN_W - 16'd1) begin
            frames_d = frames_q + 16'd1;
            if (occ_d != 2'd0) begin
              state_d = LAUNCH;
            end else begin
              state_d = IDLE;
              // The very first frame finishing with nothing queued is start-up, not starvation.
              if (frames_q != 16'd0) begin
                underrun_d = 1'b1;
              end
            end
          end else begin
            play_cnt_d = play_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      enc_v_q      <= 1'b0;
      enc_x_q      <= 16'd0;
      out_v_q      <= 1'b0;
      out_synth_q  <= 16'd0;
      smp_cnt_q    <= 16'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      buf_voiced_q <= 2'b00;
      buf_a_q      <= '{default: '0};
      buf_pr_q     <= '{default: '0};
      dec_voiced_q <= 1'b0;
      dec_a_q      <= 176'd0;
      dec_pr_q     <= 16'd0;
      play_cnt_q   <= 16'd0;
      frames_q     <= 16'd0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enc_v_q      <= enc_v_d;
      enc_x_q      <= enc_x_d;
      out_v_q      <= out_v_d;
      out_synth_q  <= out_synth_d;
      smp_cnt_q    <= smp_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      buf_voiced_q <= buf_voiced_d;
      buf_a_q      <= buf_a_d;
      buf_pr_q     <= buf_pr_d;
      dec_voiced_q <= dec_voiced_d;
      dec_a_q      <= dec_a_d;
      dec_pr_q     <= dec_pr_d;
      play_cnt_q   <= play_cnt_d;
      frames_q     <= frames_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign enc_v         = enc_v_q;
  assign enc_x         = enc_x_q;
  assign out_v         = out_v_q;
  assign out_synth     = out_synth_q;
  assign smp_cnt       = smp_cnt_q;
  assign dec_v         = (state_q == LAUNCH);
  assign dec_voiced    = dec_voiced_q;
  assign dec_a         = dec_a_q;
  assign dec_pulserate = dec_pr_q;
  assign dec_lpcrate   = FRAME_LEN_W;
  assign frames_played = frames_q;
  assign overrun       = overrun_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_lpc_frame_ctrl.sv
// Self-checking bench for lpc_frame_ctrl: queue-based frame scheduling model plus directed literal checks.
// Honours LPC_FRAME_CTRL_PITCH_CLAMP_EN the same way the design does.
module tb_lpc_frame_ctrl;

   logic         clk;
   logic         rst;
   logic         smp_v;
   logic [15:0]  smp_x;
   logic         enc_v;
   logic [15:0]  enc_x;
   logic         enc_vout;
   logic         enc_voiced;
   logic [175:0] enc_a;
   logic [15:0]  enc_freq_count;
   logic         dec_v;
   logic         dec_voiced;
   logic [175:0] dec_a;
   logic [15:0]  dec_pulserate;
   logic [15:0]  dec_lpcrate;
   logic         dec_vout;
   logic [15:0]  dec_synth;
   logic         out_v;
   logic [15:0]  out_synth;
   logic [15:0]  smp_cnt;
   logic [15:0]  frames_played;
   logic         overrun;
   logic         underrun;

   int nChecks = 0;
   int nFails  = 0;
   logic [175:0] stimA;

   lpc_frame_ctrl dut (
      .clk(clk), .rst(rst),
      .smp_v(smp_v), .smp_x(smp_x),
      .enc_v(enc_v), .enc_x(enc_x),
      .enc_vout(enc_vout), .enc_voiced(enc_voiced), .enc_a(enc_a), .enc_freq_count(enc_freq_count),
      .dec_v(dec_v), .dec_voiced(dec_voiced), .dec_a(dec_a),
      .dec_pulserate(dec_pulserate), .dec_lpcrate(dec_lpcrate),
      .dec_vout(dec_vout), .dec_synth(dec_synth),
      .out_v(out_v), .out_synth(out_synth),
      .smp_cnt(smp_cnt), .frames_played(frames_played),
      .overrun(overrun), .underrun(underrun)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports a FAIL line when actual differs from expected.
   task automatic checkOutput(input string name, input logic [175:0] actual, input logic [175:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs at a falling edge and returns at the next falling edge.
   task automatic applyStimulus(input logic r, input logic ev, input logic evoiced,
                                input logic [15:0] efc, input logic dv);
      rst            = r;
      smp_v          = 1'($urandom_range(0, 1));
      smp_x          = 16'($urandom);
      enc_vout       = ev;
      enc_voiced     = evoiced;
      enc_a          = stimA;
      enc_freq_count = efc;
      dec_vout       = dv;
      dec_synth      = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic randomizeA();
      for (int i = 0; i < 11; i++) stimA[i*16 +: 16] = 16'($urandom);
   endtask

   // Reference model: a queue of pending frames and a countdown of samples still owed by the playing frame.
   typedef struct {
      logic         voiced;
      logic [175:0] a;
      logic [15:0]  rate;
   } frame_t;

   frame_t       fifo[$];
   bit           modelValid = 0;
   bit           playing;
   int           samplesLeft;
   int           mSmpCnt;
   int           mFrames;
   logic         mEncV, mOutV, mDecV, mDecVoiced, mOverrun, mUnderrun;
   logic [15:0]  mEncX, mOutSynth, mDecRate;
   logic [175:0] mDecA;

   function automatic logic [15:0] modelRate(input logic voiced, input logic [15:0] freq);
      if (!voiced) return 16'd20;
`ifdef LPC_FRAME_CTRL_PITCH_CLAMP_EN
      if (freq < 16'd20)  return 16'd20;
      if (freq > 16'd400) return 16'd400;
`endif
      return freq;
   endfunction

   // Model advances on each rising edge using the inputs held since the previous falling edge.
   always @(posedge clk) begin
      frame_t f;
      bit     wasLaunch;
      bit     done;
      int     framesBefore;
      if (rst) begin
         fifo.delete();
         modelValid = 1;
         playing = 0; samplesLeft = 0; mSmpCnt = 0; mFrames = 0;
         mEncV = 0; mOutV = 0; mDecV = 0; mDecVoiced = 0; mOverrun = 0; mUnderrun = 0;
         mEncX = 0; mOutSynth = 0; mDecRate = 0; mDecA = '0;
      end else if (modelValid) begin
         mEncV = smp_v; mEncX = smp_x; mOutV = dec_vout; mOutSynth = dec_synth;
         if (smp_v) mSmpCnt = (mSmpCnt + 1) % 160;
         wasLaunch = mDecV;
         mDecV = 0;
         done = 0;
         if (wasLaunch) begin
            f = fifo.pop_front();
            mDecVoiced = f.voiced; mDecA = f.a; mDecRate = f.rate;
            playing = 1; samplesLeft = 160;
         end else if (playing && dec_vout) begin
            samplesLeft--;
            if (samplesLeft == 0) begin
               done = 1;
               playing = 0;
            end
         end
         if (enc_vout) begin
            if (fifo.size() < 2) begin
               f.voiced = enc_voiced; f.a = enc_a; f.rate = modelRate(enc_voiced, enc_freq_count);
               fifo.push_back(f);
            end else begin
               mOverrun = 1;
            end
         end
         if (done) begin
            framesBefore = mFrames;
            mFrames = (mFrames + 1) % 65536;
            if (fifo.size() == 0 && framesBefore != 0) mUnderrun = 1;
         end
         if (!playing && !wasLaunch && fifo.size() > 0) mDecV = 1;
      end
   end

   // Every falling edge after the first reset, all outputs are checked against the model.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("enc_v", enc_v, mEncV);
         checkOutput("enc_x", enc_x, mEncX);
         checkOutput("out_v", out_v, mOutV);
         checkOutput("out_synth", out_synth, mOutSynth);
         checkOutput("smp_cnt", smp_cnt, 16'(mSmpCnt));
         checkOutput("dec_v", dec_v, mDecV);
         checkOutput("dec_voiced", dec_voiced, mDecVoiced);
         checkOutput("dec_a", dec_a, mDecA);
         checkOutput("dec_pulserate", dec_pulserate, mDecRate);
         checkOutput("dec_lpcrate", dec_lpcrate, 16'd160);
         checkOutput("frames_played", frames_played, 16'(mFrames));
         checkOutput("overrun", overrun, mOverrun);
         checkOutput("underrun", underrun, mUnderrun);
      end
   end

   task automatic idleCycles(input int n, input logic dv);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, dv);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_enc_v"}, enc_v, 1'b0);
      checkOutput({tag, "_out_v"}, out_v, 1'b0);
      checkOutput({tag, "_dec_v"}, dec_v, 1'b0);
      checkOutput({tag, "_dec_pr"}, dec_pulserate, 16'd0);
      checkOutput({tag, "_dec_a"}, dec_a, 176'd0);
      checkOutput({tag, "_lpcrate"}, dec_lpcrate, 16'd160);
      checkOutput({tag, "_frames"}, frames_played, 16'd0);
      checkOutput({tag, "_smp_cnt"}, smp_cnt, 16'd0);
      checkOutput({tag, "_overrun"}, overrun, 1'b0);
      checkOutput({tag, "_underrun"}, underrun, 1'b0);
   endtask

   initial begin
      rst = 1'b1; smp_v = 0; smp_x = 0; enc_vout = 0; enc_voiced = 0; enc_a = '0;
      enc_freq_count = 0; dec_vout = 0; dec_synth = 0; stimA = '0;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      checkResetState("rst0");

      // First voiced frame: launch the cycle after the push, fields valid one cycle later.
      randomizeA();
      stimA[15:0] = 16'h1000;
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd80, 1'b0);
      checkOutput("lit_dec_v_launch", dec_v, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      checkOutput("lit_dec_v_once", dec_v, 1'b0);
      checkOutput("lit_pr80", dec_pulserate, 16'd80);
      checkOutput("lit_a0", dec_a[15:0], 16'h1000);
      checkOutput("lit_voiced", dec_voiced, 1'b1);
      idleCycles(159, 1'b1);
      checkOutput("lit_frames_159", frames_played, 16'd0);
      idleCycles(1, 1'b1);
      checkOutput("lit_frames_1", frames_played, 16'd1);
      checkOutput("lit_no_underrun", underrun, 1'b0);
      idleCycles(3, 1'b0);
      checkOutput("lit_idle_no_dec_v", dec_v, 1'b0);

      // Unvoiced frame: rate forced to the minimum; second empty-buffer finish is an underrun.
      randomizeA();
      applyStimulus(1'b0, 1'b1, 1'b0, 16'd999, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      checkOutput("lit_unvoiced_pr", dec_pulserate, 16'd20);
      checkOutput("lit_unvoiced_flag", dec_voiced, 1'b0);
      idleCycles(160, 1'b1);
      checkOutput("lit_frames_2", frames_played, 16'd2);
      checkOutput("lit_underrun", underrun, 1'b1);

      // Voiced extremes, with and without clamping.
      randomizeA();
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd5, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
`ifdef LPC_FRAME_CTRL_PITCH_CLAMP_EN
      checkOutput("lit_pr_low", dec_pulserate, 16'd20);
`else
      checkOutput("lit_pr_low", dec_pulserate, 16'd5);
`endif
      idleCycles(160, 1'b1);
      randomizeA();
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd1000, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
`ifdef LPC_FRAME_CTRL_PITCH_CLAMP_EN
      checkOutput("lit_pr_high", dec_pulserate, 16'd400);
`else
      checkOutput("lit_pr_high", dec_pulserate, 16'd1000);
`endif
      idleCycles(160, 1'b1);

      // Clean slate, then overfill the buffer while one frame plays.
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      checkResetState("rst1");
      for (int i = 0; i < 3; i++) begin
         randomizeA();
         applyStimulus(1'b0, 1'b1, 1'b1, 16'(100 + i), 1'b0);
      end
      checkOutput("lit_no_overrun_yet", overrun, 1'b0);
      checkOutput("lit_first_playing_pr", dec_pulserate, 16'd100);
      randomizeA();
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd200, 1'b0);
      checkOutput("lit_overrun", overrun, 1'b1);

      // Reset after 50 samples of play abandons everything.
      idleCycles(50, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
      checkResetState("rst_mid");
      idleCycles(20, 1'b1);
      checkOutput("lit_no_dec_v_after_rst", dec_v, 1'b0);
      checkOutput("lit_frames_after_rst", frames_played, 16'd0);
      randomizeA();
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd77, 1'b0);
      checkOutput("lit_dec_v_after_rst", dec_v, 1'b1);

      // Randomized traffic; the per-cycle compare against the model does the checking.
      for (int i = 0; i < 6000; i++) begin
         randomizeA();
         applyStimulus(1'($urandom_range(0, 2999) == 0),
                       1'($urandom_range(0, 149) == 0),
                       1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 1200)),
                       1'($urandom_range(0, 3) != 0));
      end
      idleCycles(2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
